jt08_adpcm_slot_ctl: RTL and testbench

Slot scheduler and register-update controller for the 6-channel ADPCM-A gain pipeline. It generates the rotating one-hot channel slot (`cur_ch`) and the per-channel new-sample strobe (`match`), and keeps the key-on enable mask (`en_ch`). It also queues CPU level/pan writes and presents each write as `up_ch`/`lracl` exactly on the `cen` tick where the target channel occupies stage I. It sits between the register interface and the gain/accumulator datapath, on the same `clk`/`cen` domain.

---
 rtl/jt08_adpcm_pkg.sv | 18 +
 rtl/jt08_slot_wrq.sv | 78 +++++++
 rtl/jt08_adpcm_slot_ctl.sv | 88 ++++++++
 tb/tb_jt08_adpcm_slot_ctl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/jt08_adpcm_pkg.sv
// Shared constants, queue entry type and slot helper for the ADPCM-A slot controller.
package jt08_adpcm_pkg;

  localparam int unsigned NCH     = 6;
  localparam int unsigned NSLOT   = 6;
  localparam logic [2:0]  CH_NONE = 3'd7;

  typedef struct packed {
    logic [2:0] ch;
    logic [7:0] data;
  } wrq_ent_t;

  // Channels 6 and 7 have no slot, so they map to an all-zero mask.
  function automatic logic [5:0] ch2onehot(input logic [2:0] ch);
    return (ch < 3'(NCH)) ? (6'd1 << ch) : '0;
  endfunction

endpackage

// File: rtl/jt08_slot_wrq.sv
// Level/pan write FIFO. JT08_SLOT_CTL_COALESCE_EN lets a push overwrite a pending
// non-head entry of the same channel instead of taking a new slot.
module jt08_slot_wrq
  import jt08_adpcm_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     wr_en,
  input  wrq_ent_t wr_ent,
  input  logic     rd_en,
  output wrq_ent_t head,
  output logic     empty,
  output logic     full,
  output logic     coal_hit
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  wrq_ent_t      mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          push;

`ifdef JT08_SLOT_CTL_COALESCE_EN
  logic [PW-1:0] coal_idx;

  // The head is skipped: it may be on its way out on this very edge.
  always_comb begin
    coal_hit = 1'b0;
    coal_idx = '0;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      if (!coal_hit && (CW'(i) < count) && (mem[rd_ptr + PW'(i)].ch == wr_ent.ch)) begin
        coal_hit = 1'b1;
        coal_idx = rd_ptr + PW'(i);
      end
    end
  end
`else
  assign coal_hit = 1'b0;
`endif

  assign push  = wr_en && !coal_hit;
  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_ent;
    end
`ifdef JT08_SLOT_CTL_COALESCE_EN
    else if (wr_en) begin
      mem[coal_idx].data <= wr_ent.data;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + PW'(1);
      if (rd_en) rd_ptr <= rd_ptr + PW'(1);
      unique case ({push, rd_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/jt08_adpcm_slot_ctl.sv
// ADPCM-A slot rotation, frame counter, key-on mask and slot-aligned level/pan updates.
// Write coalescing is selected by JT08_SLOT_CTL_COALESCE_EN (see jt08_slot_wrq).
module jt08_adpcm_slot_ctl
  import jt08_adpcm_pkg::*;
#(
  parameter int unsigned QDEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cen,
  input  logic       wr_req,
  input  logic [2:0] wr_ch,
  input  logic [7:0] wr_data,
  output logic       wr_ack,
  input  logic       kon_we,
  input  logic [7:0] kon_data,
  output logic [5:0] cur_ch,
  output logic [5:0] en_ch,
  output logic       match,
  output logic [2:0] up_ch,
  output logic [7:0] lracl,
  output logic       q_full
);

  logic [2:0] fcnt;
  wrq_ent_t   head;
  logic       q_empty;
  logic       coal_hit;
  logic       pop;
  logic       wr_valid;
  logic       accept;
  logic       kon_unused;

  assign kon_unused = kon_data[6];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_ch <= 6'b000001;
      fcnt   <= '0;
    end else if (cen) begin
      cur_ch <= {cur_ch[4:0], cur_ch[5]};
      if (cur_ch[5]) begin
        fcnt <= (fcnt == 3'(NSLOT - 1)) ? '0 : fcnt + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_ch <= '0;
    end else if (kon_we) begin
      en_ch <= kon_data[7] ? (en_ch & ~kon_data[5:0]) : (en_ch | kon_data[5:0]);
    end
  end

  assign match = (fcnt == '0) && |(cur_ch & en_ch);

  // A slot freed by this edge's pop, or an in-place coalesce, lets a full queue accept.
  // Invalid channels need no space; !wr_ack stops a held request being taken twice.
  always_comb begin
    pop      = cen && !q_empty && (cur_ch == ch2onehot(head.ch));
    wr_valid = (wr_ch < 3'(NCH));
    accept   = wr_req && !wr_ack && (!wr_valid || !q_full || pop || coal_hit);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wr_ack <= 1'b0;
    else        wr_ack <= accept;
  end

  jt08_slot_wrq #(
    .DEPTH (QDEPTH)
  ) u_wrq (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (accept && wr_valid),
    .wr_ent   ('{ch: wr_ch, data: wr_data}),
    .rd_en    (pop),
    .head     (head),
    .empty    (q_empty),
    .full     (q_full),
    .coal_hit (coal_hit)
  );

  assign up_ch = q_empty ? CH_NONE : head.ch;
  assign lracl = q_empty ? '0 : head.data;

endmodule

// File: tb/tb_jt08_adpcm_slot_ctl.sv
// Self-checking bench for jt08_adpcm_slot_ctl against a tick-count/queue reference model.
module tb_jt08_adpcm_slot_ctl;
  import jt08_adpcm_pkg::*;

  localparam int unsigned QD = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cen = 1'b0;
  logic       wr_req = 1'b0;
  logic [2:0] wr_ch = '0;
  logic [7:0] wr_data = '0;
  logic       wr_ack;
  logic       kon_we = 1'b0;
  logic [7:0] kon_data = '0;
  logic [5:0] cur_ch;
  logic [5:0] en_ch;
  logic       match;
  logic [2:0] up_ch;
  logic [7:0] lracl;
  logic       q_full;

  always #5 clk = ~clk;

  jt08_adpcm_slot_ctl #(
    .QDEPTH (QD)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cen      (cen),
    .wr_req   (wr_req),
    .wr_ch    (wr_ch),
    .wr_data  (wr_data),
    .wr_ack   (wr_ack),
    .kon_we   (kon_we),
    .kon_data (kon_data),
    .cur_ch   (cur_ch),
    .en_ch    (en_ch),
    .match    (match),
    .up_ch    (up_ch),
    .lracl    (lracl),
    .q_full   (q_full)
  );

  // Reference: slot and frame follow from the cen count since reset.
  typedef struct {
    int ch;
    int data;
  } ent_t;

  int         ticks;
  logic [5:0] m_en;
  logic       m_ack;
  ent_t       q[$];
  int         cen_mode;
  int         checks;
  int         errors;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int slot;
    int frame;
    slot  = ticks % 6;
    frame = (ticks / 6) % 6;
    chk("cur_ch", 8'(cur_ch), 8'(1 << slot));
    chk("en_ch",  8'(en_ch),  8'(m_en));
    chk("match",  8'(match),  8'((frame == 0) && m_en[slot]));
    chk("up_ch",  8'(up_ch),  8'((q.size() > 0) ? q[0].ch : 7));
    chk("lracl",  lracl,      8'((q.size() > 0) ? q[0].data : 0));
    chk("q_full", 8'(q_full), 8'(q.size() == QD));
    chk("wr_ack", 8'(wr_ack), 8'(m_ack));
  endtask

  task automatic tick();
    int   slot;
    int   ci;
    bit   do_pop;
    bit   acc;
    bit   valid;
    ent_t e;
    case (cen_mode)
      0:       cen = 1'b0;
      1:       cen = 1'b1;
      default: cen = ($urandom_range(2) == 0);
    endcase
    @(posedge clk);
    slot   = ticks % 6;
    do_pop = cen && (q.size() > 0) && (q[0].ch == slot);
    acc    = 0;
    valid  = 0;
    ci     = -1;
    if (wr_req && !m_ack) begin
      valid = (wr_ch < 6);
`ifdef JT08_SLOT_CTL_COALESCE_EN
      for (int i = 1; i < q.size(); i++)
        if (ci < 0 && q[i].ch == int'(wr_ch)) ci = i;
`endif
      acc = !valid || (ci >= 0) || (q.size() < QD) || do_pop;
    end
    if (acc && valid && ci >= 0) q[ci].data = int'(wr_data);
    if (do_pop) void'(q.pop_front());
    if (acc && valid && ci < 0) begin
      e.ch   = int'(wr_ch);
      e.data = int'(wr_data);
      q.push_back(e);
    end
    m_ack = acc;
    if (kon_we) m_en = kon_data[7] ? (m_en & ~kon_data[5:0]) : (m_en | kon_data[5:0]);
    if (cen) ticks++;
    #1;
    check_all();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic key(input logic [7:0] d);
    kon_we   = 1'b1;
    kon_data = d;
    tick();
    kon_we   = 1'b0;
  endtask

  // A stalled write with cen held low lets the pipeline run after a few cycles.
  task automatic do_write(input logic [2:0] ch, input logic [7:0] d);
    int saved;
    int n;
    saved   = cen_mode;
    wr_req  = 1'b1;
    wr_ch   = ch;
    wr_data = d;
    n       = 0;
    do begin
      tick();
      n++;
      if (n == 4 && cen_mode == 0) cen_mode = 1;
    end while (!m_ack && n < 400);
    chk("wr_ack_timeout", 8'(m_ack), 8'd1);
    wr_req   = 1'b0;
    cen_mode = saved;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    ticks = 0;
    m_en  = '0;
    m_ack = 1'b0;
    q.delete();
    check_all();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    ticks    = 0;
    m_en     = '0;
    m_ack    = 1'b0;
    cen_mode = 0;

    repeat (2) @(negedge clk);
    check_all();
    rst_n = 1'b1;

    // One full frame with nothing keyed on.
    cen_mode = 1;
    idle(36);

    key(8'h05);
    idle(40);
    key(8'h81);
    idle(40);

    // Ch3 write issued while slot 0 is current.
    while (ticks % 6 != 0) tick();
    do_write(3'd3, 8'hC8);
    idle(8);

    // Fill the queue with cen low; the fifth write waits for the first pop.
    cen_mode = 0;
    do_write(3'd4, 8'($urandom));
    do_write(3'd1, 8'($urandom));
    do_write(3'd0, 8'($urandom));
    do_write(3'd2, 8'($urandom));
    do_write(3'd5, 8'($urandom));
    cen_mode = 1;
    idle(30);

    cen_mode = 0;
    do_write(3'd5, 8'h10);
    do_write(3'd2, 8'h20);
    do_write(3'd2, 8'h30);
    cen_mode = 1;
    idle(14);

    do_write(3'd6, 8'hAA);
    do_write(3'd7, 8'h55);
    idle(2);

    // Reset with queued writes and all channels keyed on.
    cen_mode = 0;
    key(8'h3F);
    do_write(3'd1, 8'h11);
    do_write(3'd3, 8'h33);
    do_write(3'd4, 8'h44);
    do_reset();
    cen_mode = 1;
    idle(12);

    repeat (150) begin
      cen_mode = int'($urandom_range(2));
      case ($urandom_range(9))
        0, 1:          key(8'($urandom));
        2, 3, 4, 5, 6: do_write(3'($urandom_range(7)), 8'($urandom));
        default:       idle(int'($urandom_range(8, 1)));
      endcase
    end
    cen_mode = 1;
    idle(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
